// File: rtl/checker_pkg.sv
// checker_pkg: shared state encoding and compare helpers for checker_nlane
package checker_pkg;
  localparam int MAX_LANES = 32;
  localparam int MAX_BUS = 2048;
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, CHECK = 2'd2} state_t;
  // Case inequality per bit, so X or Z on either side flags the owning lane
  function automatic logic [MAX_LANES-1:0] lane_mask(input logic [MAX_BUS-1:0] s, input logic [MAX_BUS-1:0] b,
                                                     input int lanes, input int width);
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int k = 0; k < MAX_BUS; k++)
      if (k < lanes * width && s[11'(k)] !== b[11'(k)]) m[5'(k / width)] = 1'b1;
    return m;
  endfunction
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] top;
    top = w >= 64 ? '1 : (64'd1 << w) - 64'd1;
    return v == top ? v : v + 64'd1;
  endfunction
endpackage

// File: rtl/checker_delay_line.sv
// checker_delay_line: DEPTH-stage alignment shift register, wire-through when DEPTH=0
module checker_delay_line #(
  parameter int WIDTH_BUS = 1,
  parameter int DEPTH = 0
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic [WIDTH_BUS-1:0] d,
  output logic [WIDTH_BUS-1:0] q
);
  if (DEPTH == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset_L;
    assign q = d;
  end else begin : g_shift
    logic [WIDTH_BUS-1:0] sr [DEPTH];
    always_ff @(posedge clk or negedge reset_L)
      if (!reset_L) begin
        for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
      end else begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    assign q = sr[DEPTH-1];
  end
endmodule

// File: rtl/checker_nlane.sv
// checker_nlane: lane-by-lane structural vs behavioral comparator with alignment,
// warm-up masking, sticky flags, saturating counters and first-failure capture
module checker_nlane
  import checker_pkg::*;
#(
  parameter int LANES = 4,
  parameter int WIDTH = 1,
  parameter int DELAY = 0,
  parameter int SKIP  = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic                   enable,
  input  logic                   clear,
  input  logic                   valid,
  input  logic [LANES*WIDTH-1:0] out_s,
  input  logic [LANES*WIDTH-1:0] out_b,
  output logic                   test,
  output logic                   sticky_err,
  output logic [LANES-1:0]       lane_err,
  output logic [CNT_W-1:0]       err_count,
  output logic [CNT_W-1:0]       cmp_count,
  output logic [CNT_W-1:0]       first_cycle,
  output logic [LANES-1:0]       first_mask,
  output logic [1:0]             state
);
  localparam int N  = LANES * WIDTH;
  localparam int FN = DELAY + SKIP;
  localparam int FW = $clog2(FN + 2);
  logic [N-1:0] b_al;
  logic v_al;
  state_t st, st_nx;
  logic [FW-1:0] cnt, cnt_nx;
  logic [LANES-1:0] mask;
  logic [CNT_W-1:0] cmp_nx, err_nx;
  logic cmp, bad, dec;
  checker_delay_line #(.WIDTH_BUS(N), .DEPTH(DELAY)) u_data (
    .clk(clk), .reset_L(reset_L), .d(out_b), .q(b_al)
  );
  checker_delay_line #(.WIDTH_BUS(1), .DEPTH(DELAY)) u_valid (
    .clk(clk), .reset_L(reset_L), .d(valid), .q(v_al)
  );
  // While cnt is above SKIP the delay line is still filling, so every cycle counts
  always_comb begin
    dec = cnt > FW'(SKIP) || v_al;
    st_nx = !enable ? IDLE :
            st == IDLE ? FILL :
            st == FILL && (cnt == '0 || (dec && cnt == FW'(1))) ? CHECK : st;
    cnt_nx = st == IDLE ? FW'(FN) : st == FILL && dec && cnt != '0 ? cnt - FW'(1) : cnt;
  end
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) begin
      st <= IDLE;
      cnt <= '0;
    end else begin
      st <= st_nx;
      cnt <= cnt_nx;
    end
  always_comb begin
    mask = LANES'(lane_mask(MAX_BUS'(out_s), MAX_BUS'(b_al), LANES, WIDTH));
    cmp = st == CHECK && v_al;
    bad = cmp && |mask;
    cmp_nx = CNT_W'(sat_inc(64'(cmp_count), CNT_W));
    err_nx = CNT_W'(sat_inc(64'(err_count), CNT_W));
  end
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L || clear) begin
      test <= 1'b0;
      sticky_err <= 1'b0;
      lane_err <= '0;
      err_count <= '0;
      cmp_count <= '0;
      first_cycle <= '0;
      first_mask <= '0;
    end else begin
      test <= bad;
      if (cmp) cmp_count <= cmp_nx;
      if (bad) begin
        sticky_err <= 1'b1;
        lane_err <= lane_err | mask;
        err_count <= err_nx;
        if (!sticky_err) begin
          first_cycle <= cmp_nx;
          first_mask <= mask;
        end
      end
    end
  assign state = st;
endmodule

// File: tb/tb_checker_nlane.sv
// tb_checker_nlane: random-stream bench for checker_nlane against a cycle-level reference model
module tb_checker_nlane;
  logic clk = 1'b0, reset_L = 1'b0, enable = 1'b0, clear = 1'b0, valid = 1'b0;
  logic [31:0] out_b = '0, s0 = '0, s1 = '0;
  logic t0, se0, t1, se1;
  logic [3:0] le0, fm0, le1, fm1;
  logic [15:0] ec0, cc0, fc0;
  logic [3:0] ec1, cc1, fc1;
  logic [1:0] st0, st1;
  int checks = 0, failures = 0, t0_high = 0;
  always #5 clk = ~clk;

  checker_nlane #(.LANES(4), .WIDTH(8), .DELAY(0), .SKIP(0), .CNT_W(16)) dut0 (
    .clk(clk), .reset_L(reset_L), .enable(enable), .clear(clear), .valid(valid),
    .out_s(s0), .out_b(out_b), .test(t0), .sticky_err(se0), .lane_err(le0),
    .err_count(ec0), .cmp_count(cc0), .first_cycle(fc0), .first_mask(fm0), .state(st0)
  );
  checker_nlane #(.LANES(4), .WIDTH(8), .DELAY(3), .SKIP(2), .CNT_W(4)) dut1 (
    .clk(clk), .reset_L(reset_L), .enable(enable), .clear(clear), .valid(valid),
    .out_s(s1), .out_b(out_b), .test(t1), .sticky_err(se1), .lane_err(le1),
    .err_count(ec1), .cmp_count(cc1), .first_cycle(fc1), .first_mask(fm1), .state(st1)
  );

  // Reference model: one entry per DUT; behavioral history kept as plain queues
  int dd[2] = '{0, 3};
  int ss[2] = '{0, 2};
  int cmax[2] = '{65535, 15};
  int m_mode[2], m_fl[2], m_sl[2], m_cc[2], m_ec[2], m_fc[2];
  logic m_t[2], m_se[2];
  logic [3:0] m_le[2], m_fm[2];
  logic [31:0] hb[$];
  logic hv[$];
  logic [31:0] past[$];
  logic [31:0] prev_b = '0;

  function automatic void m_reset();
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = 0; m_fl[d] = 0; m_sl[d] = 0; m_cc[d] = 0; m_ec[d] = 0; m_fc[d] = 0;
      m_t[d] = 1'b0; m_se[d] = 1'b0; m_le[d] = '0; m_fm[d] = '0;
    end
    hb.delete();
    hv.delete();
  endfunction

  function automatic void m_edge(input logic en, input logic cl, input logic v,
                                 input logic [31:0] b, input logic [31:0] sa, input logic [31:0] sb);
    logic [31:0] ab, s;
    logic av;
    logic [3:0] mm;
    bit cmp;
    for (int d = 0; d < 2; d++) begin
      s = d == 0 ? sa : sb;
      ab = dd[d] == 0 ? b : (hb.size() >= dd[d] ? hb[hb.size() - dd[d]] : 32'h0);
      av = dd[d] == 0 ? v : (hv.size() >= dd[d] ? hv[hv.size() - dd[d]] : 1'b0);
      for (int i = 0; i < 4; i++) mm[i] = s[i*8 +: 8] !== ab[i*8 +: 8];
      cmp = m_mode[d] == 2 && av === 1'b1;
      if (cl) begin
        m_t[d] = 1'b0; m_se[d] = 1'b0; m_le[d] = '0; m_cc[d] = 0; m_ec[d] = 0; m_fc[d] = 0; m_fm[d] = '0;
      end else begin
        m_t[d] = cmp && mm != 0;
        if (cmp) begin
          if (m_cc[d] < cmax[d]) m_cc[d]++;
          if (mm != 0) begin
            if (!m_se[d]) begin
              m_fc[d] = m_cc[d];
              m_fm[d] = mm;
            end
            m_se[d] = 1'b1;
            m_le[d] = m_le[d] | mm;
            if (m_ec[d] < cmax[d]) m_ec[d]++;
          end
        end
      end
      if (!en) m_mode[d] = 0;
      else if (m_mode[d] == 0) begin
        m_mode[d] = 1; m_fl[d] = dd[d]; m_sl[d] = ss[d];
      end else if (m_mode[d] == 1) begin
        if (m_fl[d] > 0) m_fl[d]--;
        else if (m_sl[d] > 0 && av === 1'b1) m_sl[d]--;
        if (m_fl[d] == 0 && m_sl[d] == 0) m_mode[d] = 2;
      end
    end
    hb.push_back(b);
    hv.push_back(v);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("test0", t0, m_t[0]);       chk("test1", t1, m_t[1]);
    chk("sticky0", se0, m_se[0]);   chk("sticky1", se1, m_se[1]);
    chk("lane_err0", le0, m_le[0]); chk("lane_err1", le1, m_le[1]);
    chk("err_cnt0", ec0, m_ec[0]);  chk("err_cnt1", ec1, m_ec[1]);
    chk("cmp_cnt0", cc0, m_cc[0]);  chk("cmp_cnt1", cc1, m_cc[1]);
    chk("first_cyc0", fc0, m_fc[0]); chk("first_cyc1", fc1, m_fc[1]);
    chk("first_msk0", fm0, m_fm[0]); chk("first_msk1", fm1, m_fm[1]);
    chk("state0", st0, m_mode[0]);  chk("state1", st1, m_mode[1]);
  endtask

  task automatic step(input logic en, input logic cl, input logic v,
                      input logic [31:0] b, input logic [31:0] sa, input logic [31:0] sb);
    enable = en; clear = cl; valid = v; out_b = b; s0 = sa; s1 = sb;
    @(posedge clk);
    m_edge(en, cl, v, b, sa, sb);
    #1;
    if (t0 === 1'b1) t0_high++;
    chk_all();
  endtask

  // Fresh changing behavioral word; dut1 sees it lagged by `lag` cycles
  task automatic stream(input logic en, input logic cl, input logic v, input int lag, input logic [31:0] f0);
    logic [31:0] b, sb;
    b = $urandom;
    if (b == prev_b) b = ~b;
    prev_b = b;
    sb = past.size() >= lag ? past[past.size() - lag] : $urandom;
    past.push_back(b);
    step(en, cl, v, b, b ^ f0, sb);
  endtask

  initial begin
    int c0, e0;
    logic [31:0] b, xs;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all();
    @(negedge clk);
    reset_L = 1'b1;
    for (int i = 0; i < 200 && m_cc[0] < 100; i++) stream(1'b1, 1'b0, 1'b1, 3, 32'h0);
    chk("match_cmp0", cc0, 100);
    chk("match_err0", ec0, 0);
    chk("match_test0", t0_high, 0);
    chk("delay3_err1", ec1, 0);
    stream(1'b1, 1'b1, 1'b1, 3, 32'h0000_0100);
    chk("clr_cmp0", cc0, 0);
    chk("clr_err0", ec0, 0);
    chk("clr_test0", t0, 0);
    t0_high = 0;
    for (int i = 0; i < 200 && m_cc[0] < 100; i++)
      stream(1'b1, 1'b0, 1'b1, 3, m_cc[0] == 36 ? 32'h0001_0000 : 32'h0);
    chk("fault_first_cyc", fc0, 37);
    chk("fault_first_msk", fm0, 4'b0100);
    chk("fault_lane_err", le0, 4'b0100);
    chk("fault_err_cnt", ec0, 1);
    chk("fault_test_pulse", t0_high, 1);
    repeat (25) stream(1'b1, 1'b0, 1'b1, 2, 32'h0);
    chk("lag2_sticky1", se1, 1);
    chk("sat_err1", ec1, 15);
    chk("sat_cmp1", cc1, 15);
    stream(1'b1, 1'b1, 1'b1, 2, 32'h0);
    chk("clrmis_err1", ec1, 0);
    chk("clrmis_fc1", fc1, 0);
    chk("clrmis_le1", le1, 0);
    chk("clrmis_t1", t1, 0);
    stream(1'b1, 1'b0, 1'b1, 2, 32'h0);
    chk("recap_fc1", fc1, 1);
    chk("recap_err1", ec1, 1);
    c0 = m_cc[0];
    e0 = m_ec[0];
    repeat (8) stream(1'b1, 1'b0, 1'b0, 2, 32'hFFFF_FFFF);
    chk("vgate_cmp0", cc0, c0);
    chk("vgate_err0", ec0, e0);
    b = $urandom;
    xs = b;
    xs[7:0] = 8'hxx;
    step(1'b1, 1'b0, 1'b1, b, xs, b);
    chk("x_lane0", le0[0], 1);
    chk("x_err0", ec0, e0 + 1);
    chk("x_test0", t0, 1);
    repeat (4) stream(1'b1, 1'b0, 1'b1, 3, 32'h0);
    #3;
    reset_L = 1'b0;
    #1;
    m_reset();
    chk_all();
    chk("arst_state0", st0, 0);
    chk("arst_cmp0", cc0, 0);
    @(posedge clk);
    #1;
    chk_all();
    @(negedge clk);
    reset_L = 1'b1;
    repeat (12) stream(1'b1, 1'b0, 1'b1, 3, 32'h0);
    repeat (3) stream(1'b0, 1'b0, 1'b1, 3, 32'h0);
    chk("idle_state1", st1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
